// File: rtl/brush_stamp_scheduler.sv
// Brush stamp scheduler: rasterises a filled circle into the shared frame buffer using idle scanout cycles.
// Optional BRUSH_PENDING_EN adds a one-deep request slot so back-to-back stamps run with no IDLE gap.
module brush_stamp_scheduler #(
    parameter int CANVAS_X0  = 100,
    parameter int CANVAS_X1  = 540,
    parameter int CANVAS_Y0  = 100,
    parameter int CANVAS_Y1  = 380,
    parameter int RADIUS_MAX = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stamp_req,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  Ball_size,
    input  logic        left_btn,
    input  logic        right_btn,
    input  logic        vga_rd_req,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    output logic [9:0]  mem_x,
    output logic [9:0]  mem_y,
    output logic        mem_we,
    output logic [23:0] mem_wdata,
    output logic        stamp_busy,
    output logic        stamp_done
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [9:0]  X0    = 10'(CANVAS_X0);
    localparam logic [9:0]  X1    = 10'(CANVAS_X1);
    localparam logic [9:0]  Y0    = 10'(CANVAS_Y0);
    localparam logic [9:0]  Y1    = 10'(CANVAS_Y1);
    localparam logic [9:0]  RMAX  = 10'(RADIUS_MAX);
    localparam logic [23:0] PAINT = 24'hFF00FF;

    // Lower box edge: centre minus radius, saturated at 0, then clipped to the canvas.
    function automatic logic [9:0] box_lo(input logic [9:0] c, input logic [9:0] r,
                                          input logic [9:0] lim);
        logic [9:0] d;
        d = (c < r) ? 10'd0 : c - r;
        return (d < lim) ? lim : d;
    endfunction

    function automatic logic [9:0] box_hi(input logic [9:0] c, input logic [9:0] r,
                                          input logic [9:0] lim);
        logic [10:0] s;
        s = {1'b0, c} + {1'b0, r};
        return (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d, r_q, r_d;
    logic [9:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [23:0] colour_q, colour_d;

    logic        req_ok;
    logic [9:0]  in_r;
    logic        src_vld, src_paint;
    logic [9:0]  src_x, src_y, src_r;
    logic [9:0]  n_xs, n_xe, n_ys, n_ye;

`ifdef BRUSH_PENDING_EN
    logic        pend_vld_q, pend_vld_d, pend_paint_q, pend_paint_d;
    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_r_q, pend_r_d;
`endif

    assign req_ok = stamp_req & (left_btn | right_btn);
    assign in_r   = (Ball_size > RMAX) ? RMAX : Ball_size;

    always_comb begin
        src_x     = BallX;
        src_y     = BallY;
        src_r     = in_r;
        src_paint = left_btn;
        src_vld   = (state_q == IDLE) && req_ok;
`ifdef BRUSH_PENDING_EN
        // A request landing in DONE itself is newer than the slot, so it wins.
        if (state_q == DONE) begin
            src_vld = req_ok | pend_vld_q;
            if (!req_ok) begin
                src_x     = pend_x_q;
                src_y     = pend_y_q;
                src_r     = pend_r_q;
                src_paint = pend_paint_q;
            end
        end
`endif
        n_xs = box_lo(src_x, src_r, X0);
        n_xe = box_hi(src_x, src_r, X1);
        n_ys = box_lo(src_y, src_r, Y0);
        n_ye = box_hi(src_y, src_r, Y1);
    end

    // Circle test on the cursor; within a non-empty box |dx|,|dy| <= r so squares fit easily.
    logic signed [10:0] dx, dy;
    logic signed [21:0] dxe, dye, dx2, dy2;
    logic [21:0]        d2, r2;
    logic               hit, stall, write_en;

    always_comb begin
        dx  = $signed({1'b0, x_q}) - $signed({1'b0, cx_q});
        dy  = $signed({1'b0, y_q}) - $signed({1'b0, cy_q});
        dxe = {{11{dx[10]}}, dx};
        dye = {{11{dy[10]}}, dy};
        dx2 = dxe * dxe;
        dy2 = dye * dye;
        d2  = $unsigned(dx2) + $unsigned(dy2);
        r2  = {12'd0, r_q} * {12'd0, r_q};
        hit = (d2 <= r2);
    end

    assign stall    = (state_q == SCAN) && hit && vga_rd_req;
    assign write_en = (state_q == SCAN) && hit && !vga_rd_req;

    always_comb begin
        state_d  = state_q;
        cx_d = cx_q;  cy_d = cy_q;  r_d  = r_q;
        xs_d = xs_q;  xe_d = xe_q;  ys_d = ys_q;  ye_d = ye_q;
        x_d  = x_q;   y_d  = y_q;
        colour_d = colour_q;
        case (state_q)
            SCAN: begin
                if (!stall) begin
                    if (x_q == xe_q) begin
                        if (y_q == ye_q) begin
                            state_d = DONE;
                        end else begin
                            x_d = xs_q;
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (src_vld) begin
            cx_d     = src_x;
            cy_d     = src_y;
            r_d      = src_r;
            colour_d = src_paint ? PAINT : 24'h000000;
            xs_d = n_xs;  xe_d = n_xe;  ys_d = n_ys;  ye_d = n_ye;
            x_d  = n_xs;  y_d  = n_ys;
            state_d  = ((n_xs > n_xe) || (n_ys > n_ye)) ? DONE : SCAN;
        end
    end

`ifdef BRUSH_PENDING_EN
    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_r_d     = pend_r_q;
        pend_paint_d = pend_paint_q;
        if ((state_q == SCAN) && req_ok) begin
            pend_vld_d   = 1'b1;
            pend_x_d     = BallX;
            pend_y_d     = BallY;
            pend_r_d     = in_r;
            pend_paint_d = left_btn;
        end else if (state_q == DONE) begin
            pend_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend_vld_q   <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_r_q     <= '0;
            pend_paint_q <= 1'b0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_r_q     <= pend_r_d;
            pend_paint_q <= pend_paint_d;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cx_q <= '0;  cy_q <= '0;  r_q  <= '0;
            xs_q <= '0;  xe_q <= '0;  ys_q <= '0;  ye_q <= '0;
            x_q  <= '0;  y_q  <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cx_q <= cx_d;  cy_q <= cy_d;  r_q  <= r_d;
            xs_q <= xs_d;  xe_q <= xe_d;  ys_q <= ys_d;  ye_q <= ye_d;
            x_q  <= x_d;   y_q  <= y_d;
            colour_q <= colour_d;
        end
    end

    // Scanout owns the address bus whenever it asks, or whenever no scan is running.
    assign mem_x      = ((state_q == SCAN) && !vga_rd_req) ? x_q : vga_x;
    assign mem_y      = ((state_q == SCAN) && !vga_rd_req) ? y_q : vga_y;
    assign mem_we     = write_en;
    assign mem_wdata  = write_en ? colour_q : 24'h000000;
    assign stamp_busy = (state_q == SCAN);
    assign stamp_done = (state_q == DONE);
endmodule

// File: tb/tb_brush_stamp_scheduler.sv
// Scoreboard bench for brush_stamp_scheduler: a pixel-set reference model feeds an event queue checked by a monitor.
module tb_brush_stamp_scheduler;
`ifdef BRUSH_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic        Clk = 1'b0, Reset = 1'b0, stamp_req = 1'b0;
    logic [9:0]  BallX = '0, BallY = '0, Ball_size = '0;
    logic        left_btn = 1'b0, right_btn = 1'b0, vga_rd_req = 1'b0;
    logic [9:0]  vga_x = '0, vga_y = '0;
    logic [9:0]  mem_x, mem_y;
    logic        mem_we, stamp_busy, stamp_done;
    logic [23:0] mem_wdata;

    brush_stamp_scheduler dut (
        .Clk(Clk), .Reset(Reset), .stamp_req(stamp_req),
        .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
        .left_btn(left_btn), .right_btn(right_btn),
        .vga_rd_req(vga_rd_req), .vga_x(vga_x), .vga_y(vga_y),
        .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .stamp_busy(stamp_busy), .stamp_done(stamp_done)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        bit          is_done;
        int          x;
        int          y;
        logic [23:0] d;
        int          area;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0, n_fail = 0;
    int  done_cnt = 0, done_exp = 0;
    int  busy_cnt = 0, wr_cnt = 0, last_busy = 0, last_wr = 0;
    int  vga_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: every on-canvas pixel within radius, row-major, then one completion event.
    task automatic push_stamp(input int cx, input int cy, input int sz, input bit paint,
                              input bit timed);
        int r, xs, xe, ys, ye, area;
        ev_t e;
        r  = (sz > 15) ? 15 : sz;
        xs = (cx - r < 100) ? 100 : cx - r;
        xe = (cx + r > 540) ? 540 : cx + r;
        ys = (cy - r < 100) ? 100 : cy - r;
        ye = (cy + r > 380) ? 380 : cy + r;
        area = 0;
        if (xs <= xe && ys <= ye) begin
            area = (xe - xs + 1) * (ye - ys + 1);
            for (int y = ys; y <= ye; y++)
                for (int x = xs; x <= xe; x++)
                    if ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r) begin
                        e = '{1'b0, x, y, paint ? 24'hFF00FF : 24'h000000, 0};
                        sb.push_back(e);
                    end
        end
        e = '{1'b1, 0, 0, 24'h0, timed ? area : -1};
        sb.push_back(e);
        done_exp++;
    endtask

    task automatic issue(input int cx, input int cy, input int sz, input bit l, input bit r,
                         input bit expect_stamp, input bit timed);
        @(posedge Clk); #1;
        BallX = 10'(cx); BallY = 10'(cy); Ball_size = 10'(sz);
        left_btn = l; right_btn = r; stamp_req = 1'b1;
        if (expect_stamp && (l || r)) push_stamp(cx, cy, sz, l, timed);
        @(posedge Clk); #1;
        stamp_req = 1'b0;
        BallX = 10'($urandom_range(0, 1023)); BallY = 10'($urandom_range(0, 1023));
        Ball_size = 10'($urandom_range(0, 1023));
        left_btn = 1'($urandom_range(0, 1)); right_btn = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge Clk); #1;
            n++;
        end
        check("done_within_budget", 64'(done_cnt >= target), 64'd1);
    endtask

    initial forever begin
        @(posedge Clk); #2;
        case (vga_mode)
            0:       vga_rd_req = 1'b0;
            1:       vga_rd_req = 1'b1;
            default: vga_rd_req = ($urandom_range(0, 3) == 0);
        endcase
        vga_x = 10'($urandom_range(0, 639));
        vga_y = 10'($urandom_range(0, 479));
    end

    always @(negedge Clk) begin
        ev_t e;
        if (!Reset) begin
            busy_cnt = 0;
            wr_cnt   = 0;
        end else begin
            if (vga_rd_req) begin
                check("mux_x_vga", 64'(mem_x), 64'(vga_x));
                check("mux_y_vga", 64'(mem_y), 64'(vga_y));
                check("no_we_during_vga", 64'(mem_we), 64'd0);
            end
            if (mem_we) begin
                wr_cnt++;
                if (sb.size() == 0 || sb[0].is_done) begin
                    check("unexpected_write", {mem_x, mem_y, mem_wdata}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("write_xyd", {20'd0, mem_x, mem_y, mem_wdata},
                          {20'd0, 10'(e.x), 10'(e.y), e.d});
                end
            end
            if (stamp_busy) busy_cnt++;
            if (stamp_done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    check("unexpected_done", 64'(sb.size()), 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.area >= 0) check("scan_cycles", 64'(busy_cnt), 64'(e.area));
                end
                last_busy = busy_cnt;
                last_wr   = wr_cnt;
                busy_cnt  = 0;
                wr_cnt    = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #3;
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_busy", 64'(stamp_busy), 64'd0);
        check("rst_done", 64'(stamp_done), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;

        issue(320, 240, 2, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(done_exp, 200);
        check("basic_writes", 64'(last_wr), 64'd13);
        check("basic_cycles", 64'(last_busy), 64'd25);

        issue(320, 240, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) @(posedge Clk);
        vga_mode = 1;
        repeat (10) @(posedge Clk);
        vga_mode = 0;
        wait_done(done_exp, 200);
        check("stall_writes", 64'(last_wr), 64'd13);
        check("stall_cycles_longer", 64'(last_busy > 25), 64'd1);

        issue(100, 100, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(done_exp, 200);
        check("corner_writes", 64'(last_wr), 64'd11);
        check("corner_cycles", 64'(last_busy), 64'd16);

        issue(50, 50, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_done(done_exp, 50);
        check("empty_writes", 64'(last_wr), 64'd0);

        issue(320, 240, 40, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(done_exp, 2000);
        check("clamp_cycles", 64'(last_busy), 64'd961);

        issue(320, 240, 4, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_done(done_exp, 200);
        issue(400, 300, 3, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(done_exp, 200);

        issue(320, 240, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge Clk); #1;
        check("nobtn_idle", 64'(stamp_busy), 64'd0);
        repeat (3) @(negedge Clk);
        check("nobtn_no_done", 64'(done_cnt), 64'(done_exp));

        issue(200, 200, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge Clk);
        issue(300, 300, 2, 1'b0, 1'b1, PEND, 1'b1);
        wait_done(PEND ? done_exp - 1 : done_exp, 200);
        @(negedge Clk); #1;
        check("busy_after_done", 64'(stamp_busy), 64'(PEND));
        wait_done(done_exp, 200);

        issue(320, 240, 10, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (20) @(posedge Clk);
        #3;
        check("busy_before_reset", 64'(stamp_busy), 64'd1);
        Reset = 1'b0;
        #1;
        check("async_rst_we", 64'(mem_we), 64'd0);
        check("async_rst_busy", 64'(stamp_busy), 64'd0);
        sb.delete();
        done_exp = done_cnt;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (10) @(negedge Clk);
        check("no_done_after_reset", 64'(done_cnt), 64'(done_exp));

        vga_mode = 2;
        for (int i = 0; i < 25; i++) begin
            int b;
            b = $urandom_range(1, 3);
            issue($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 40),
                  b[0], b[1], 1'b1, 1'b0);
            wait_done(done_exp, 4000);
        end
        vga_mode = 0;
        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
